data_mem_lsu: RTL and testbench
===============================

// Module: data_mem_lsu
// PURPOSE
//  Parametrised byte-addressable RV32 data memory with built-in load/store unit.
//  Decodes funct3 sizes (B/H/W, signed/unsigned) and detects misaligned, out-of-range and illegal accesses.
//  Clears itself word-by-word after reset and uses a valid/ready request, fixed-latency response handshake.
//  Sits between the core's MEM stage and on-chip storage.
// PARAMETERS
//  DEPTH_WORDS  256          number of 32-bit words; power of 2, >=4; byte range 0..4*DEPTH_WORDS-1
//  INIT_WORD0   32'h00000005 value written to word 0 during clear; all other words cleared to 0
// PORTS
//  clk        in   1   clock, all state on rising edge
//  resetn     in   1   reset, synchronous, active-low
//  req_valid  in   1   request present
//  req_ready  out  1   block can accept a request this cycle
//  req_we     in   1   1=store, 0=load
//  req_addr   in   32  byte address
//  req_size   in   3   RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_wdata  in   32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
//  rsp_valid  out  1   one-cycle response pulse
//  rsp_rdata  out  32  load data, extended to 32 bits; 0 for stores and faults
//  rsp_fault  out  1   access rejected, qualified by rsp_valid
//  busy       out  1   clear sequence in progress
// BEHAVIOUR
//  FSM states: CLEAR and IDLE.
//   - Any clk edge with resetn=0: state<=CLEAR, clr_ptr<=0.
//   - Outputs after reset: rsp_valid=0, rsp_rdata=0, rsp_fault=0, req_ready=0, busy=1.
//  CLEAR: one word written per cycle at clr_ptr (word 0 <= INIT_WORD0, others <= 0), clr_ptr++.
//   - After writing word DEPTH_WORDS-1, go to IDLE.
//   - Takes exactly DEPTH_WORDS cycles after resetn rises.
//   - busy=1 and req_ready=0 throughout; requests are ignored.
//  IDLE: busy=0, req_ready=1.
//   - Accepted request = req_valid & req_ready.
//   - Can accept one request every cycle; there is no response backpressure.
//  Latency: a request accepted at edge N gives rsp_valid=1 for exactly the cycle after edge N.
//   - rsp_valid is 0 in cycles with no accepted request.
//  Fault (checked in this order; any hit means no write, rsp_rdata=0, rsp_fault=1):
//   - req_size in {011,110,111}, or req_size in {100,101} with req_we=1.
//   - H/HU with addr[0]=1, or W with addr[1:0]!=0.
//   - req_addr >= 4*DEPTH_WORDS (upper address bits are checked, not truncated).
//  Word index = addr[clog2(DEPTH_WORDS)+1:2]; byte lane = addr[1:0].
//  Stores update only the addressed lanes at edge N:
//   - SB writes lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}; SW writes all 4.
//   - Other bytes are unchanged. rsp_rdata=0 and rsp_fault=0.
//  Loads sample storage at edge N:
//   - B/H sign-extend; BU/HU zero-extend; W returns the full word.
//   - Little-endian: lane 0 = bits [7:0].
//  Store at edge N followed by a load accepted at edge N+1 to the same bytes returns the new data.
//  Reset mid-operation: a pending response is dropped (rsp_valid=0 after the reset edge) and CLEAR restarts at word 0.
//  Reset in the middle of CLEAR also restarts it at word 0.
// TESTING  (DEPTH_WORDS=256)
//  1. Release reset, then count cycles: busy=1 and req_ready=0 for exactly 256 cycles, then LW 0x0 -> rsp_rdata=0x00000005.
//  2. SW 0x10=0x8081F2F3, then back-to-back LB 0x10 / LBU 0x11 / LH 0x12 / LHU 0x12:
//     -> 0xFFFFFFF3, 0x000000F2, 0xFFFF8081, 0x00008081, one rsp per cycle.
//  3. SB 0x21=0xAB onto a word holding 0x11223344 -> LW 0x20 returns 0x1122AB44; the other bytes are unchanged.
//  4. LH 0x03, SW 0x06, LW 0x400, req_size=011 -> each gives rsp_fault=1 and rsp_rdata=0; memory contents are unchanged.
//  5. Assert resetn=0 for 1 cycle the cycle after a store is accepted -> no rsp_valid, busy=1, and the word reads 0 after the clear.
//  6. Assert resetn=0 at clr_ptr=100 -> the clear restarts and takes a full 256 cycles from the release.

Source files
------------

// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the MEM stage and the data memory LSU.
interface data_mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, busy
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-addressable RV32 data memory with load/store decode, fault detection
// and a self-clear sequence after reset; fixed one-cycle response latency.
module data_mem_lsu #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] INIT_WORD0  = 32'h0000_0005
) (
  input  logic          clk,
  input  logic          resetn,
  data_mem_lsu_if.slave bus
);
  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam int unsigned BAW = AW + 2;

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_fault_q, rsp_fault_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            mem_we;
  logic [AW-1:0]   mem_idx;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_be;

  logic            accept, size_bad, misalign, out_of_range, fault;
  logic [AW-1:0]   req_idx;
  logic [1:0]      lane;
  logic [31:0]     rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;

  // Request decode; faults never write and always return zero data
  assign req_idx      = bus.req_addr[BAW-1:2];
  assign lane         = bus.req_addr[1:0];
  assign rd_word      = mem_q[req_idx];
  assign rd_byte      = 8'(rd_word >> {lane, 3'b000});
  assign rd_half      = lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign size_bad     = (bus.req_size == 3'b011) || (bus.req_size == 3'b110) ||
                        (bus.req_size == 3'b111) || (bus.req_size[2] && bus.req_we);
  assign misalign     = ((bus.req_size[1:0] == 2'b01) && lane[0]) ||
                        ((bus.req_size[1:0] == 2'b10) && (lane != 2'b00));
  assign out_of_range = |bus.req_addr[31:BAW];
  assign fault        = size_bad || misalign || out_of_range;
  assign accept       = bus.req_valid && resetn && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    rsp_valid_d = 1'b0;
    rsp_fault_d = 1'b0;
    rsp_rdata_d = 32'h0;
    mem_we      = 1'b0;
    mem_idx     = req_idx;
    mem_wdata   = bus.req_wdata;
    mem_be      = 4'hF;
    case (state_q)
      CLEAR: begin
        mem_we    = resetn;
        mem_idx   = clr_ptr_q;
        mem_wdata = (clr_ptr_q == '0) ? INIT_WORD0 : 32'h0;
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(DEPTH_WORDS - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (accept) begin
          rsp_valid_d = 1'b1;
          if (fault) begin
            rsp_fault_d = 1'b1;
          end else if (bus.req_we) begin
            mem_we = 1'b1;
            case (bus.req_size[1:0])
              2'b00: begin
                mem_wdata = {4{bus.req_wdata[7:0]}};
                mem_be    = 4'b0001 << lane;
              end
              2'b01: begin
                mem_wdata = {2{bus.req_wdata[15:0]}};
                mem_be    = lane[1] ? 4'b1100 : 4'b0011;
              end
              default: ;
            endcase
          end else begin
            case (bus.req_size)
              3'b000:  rsp_rdata_d = {{24{rd_byte[7]}}, rd_byte};
              3'b100:  rsp_rdata_d = {24'h0, rd_byte};
              3'b001:  rsp_rdata_d = {{16{rd_half[15]}}, rd_half};
              3'b101:  rsp_rdata_d = {16'h0, rd_half};
              default: rsp_rdata_d = rd_word;
            endcase
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Storage has no reset; the clear sequence initialises it
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == CLEAR);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_fault = rsp_fault_q;
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: clear timing, load/store sizes, faults, resets.
module tb_data_mem_lsu;
  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;

  data_mem_lsu_if bus ();

  data_mem_lsu #(.DEPTH_WORDS(256), .INIT_WORD0(32'h0000_0005)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                         SZ_BU = 3'b100, SZ_HU = 3'b101;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one request at a negedge, sample its response at the next negedge
  task automatic req_chk(input string tag, input logic we, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_fault);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({tag, ".valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, ".fault"}, 32'(bus.rsp_fault), 32'(exp_fault));
    check({tag, ".rdata"}, bus.rsp_rdata, exp_rdata);
  endtask

  // Count cycles until busy drops, bounded; also note any ready/rsp during clear
  task automatic wait_clear(output int n, output bit bad_seen);
    n = 0;
    bad_seen = 1'b0;
    while (bus.busy && n < 1000) begin
      if (bus.req_ready || bus.rsp_valid) bad_seen = 1'b1;
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  bit bad;
  int busy_lost;

  initial begin
    resetn        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_size  = SZ_W;
    bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);

    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst.rsp_fault", 32'(bus.rsp_fault), 32'd0);
    check("rst.req_ready", 32'(bus.req_ready), 32'd0);
    check("rst.busy",      32'(bus.busy),      32'd1);

    // Clear length; a store held valid throughout must be ignored
    resetn        = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h4;
    bus.req_size  = SZ_W;
    bus.req_wdata = 32'hDEAD_BEEF;
    wait_clear(n, bad);
    bus.req_valid = 1'b0;
    check("clr1.cycles", 32'(n), 32'd256);
    check("clr1.no_ready_rsp", 32'(bad), 32'd0);
    check("clr1.ready", 32'(bus.req_ready), 32'd1);
    req_chk("lw0", 1'b0, 32'h0, SZ_W, 32'h0, 32'h0000_0005, 1'b0);
    req_chk("lw4", 1'b0, 32'h4, SZ_W, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("idle.no_rsp", 32'(bus.rsp_valid), 32'd0);

    // Sizes and extension, back to back
    req_chk("sw10",  1'b1, 32'h10, SZ_W,  32'h8081_F2F3, 32'h0, 1'b0);
    req_chk("lb10",  1'b0, 32'h10, SZ_B,  32'h0, 32'hFFFF_FFF3, 1'b0);
    req_chk("lbu11", 1'b0, 32'h11, SZ_BU, 32'h0, 32'h0000_00F2, 1'b0);
    req_chk("lh12",  1'b0, 32'h12, SZ_H,  32'h0, 32'hFFFF_8081, 1'b0);
    req_chk("lhu12", 1'b0, 32'h12, SZ_HU, 32'h0, 32'h0000_8081, 1'b0);
    req_chk("lb13",  1'b0, 32'h13, SZ_B,  32'h0, 32'hFFFF_FF80, 1'b0);

    // Partial stores, store-to-load forwarding through storage
    req_chk("sw20",  1'b1, 32'h20, SZ_W, 32'h1122_3344, 32'h0, 1'b0);
    req_chk("sb21",  1'b1, 32'h21, SZ_B, 32'h1234_56AB, 32'h0, 1'b0);
    req_chk("lw20a", 1'b0, 32'h20, SZ_W, 32'h0, 32'h1122_AB44, 1'b0);
    req_chk("sh22",  1'b1, 32'h22, SZ_H, 32'hFFFF_7766, 32'h0, 1'b0);
    req_chk("lw20b", 1'b0, 32'h20, SZ_W, 32'h0, 32'h7766_AB44, 1'b0);
    req_chk("lw3fc", 1'b0, 32'h3FC, SZ_W, 32'h0, 32'h0, 1'b0);

    // Faults and their lack of side effects
    req_chk("f.lh03",   1'b0, 32'h03, SZ_H, 32'h0, 32'h0, 1'b1);
    req_chk("f.sw06",   1'b1, 32'h06, SZ_W, 32'hAAAA_AAAA, 32'h0, 1'b1);
    req_chk("f.lw400",  1'b0, 32'h400, SZ_W, 32'h0, 32'h0, 1'b1);
    req_chk("f.sz011",  1'b0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1);
    req_chk("f.sbu",    1'b1, 32'h10, SZ_BU, 32'h55, 32'h0, 1'b1);
    req_chk("f.swhigh", 1'b1, 32'h1000_0010, SZ_W, 32'h5555_5555, 32'h0, 1'b1);
    req_chk("f.sw400",  1'b1, 32'h400, SZ_W, 32'h9999_9999, 32'h0, 1'b1);
    req_chk("f.lw4",    1'b0, 32'h4, SZ_W, 32'h0, 32'h0, 1'b0);
    req_chk("f.lw10",   1'b0, 32'h10, SZ_W, 32'h0, 32'h8081_F2F3, 1'b0);
    req_chk("f.lw0",    1'b0, 32'h0, SZ_W, 32'h0, 32'h0000_0005, 1'b0);

    // Reset the cycle after an accepted store
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h30;
    bus.req_size  = SZ_W;
    bus.req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.req_valid = 1'b0;
    resetn        = 1'b0;
    @(negedge clk);
    check("r5.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("r5.busy",      32'(bus.busy),      32'd1);
    resetn = 1'b1;
    wait_clear(n, bad);
    check("clr2.cycles", 32'(n), 32'd256);
    req_chk("r5.lw30", 1'b0, 32'h30, SZ_W, 32'h0, 32'h0, 1'b0);
    req_chk("r5.lw0",  1'b0, 32'h0,  SZ_W, 32'h0, 32'h0000_0005, 1'b0);

    // Reset in the middle of clear restarts it
    resetn = 1'b0;
    @(negedge clk);
    resetn    = 1'b1;
    busy_lost = 0;
    repeat (100) begin
      @(negedge clk);
      if (!bus.busy) busy_lost++;
    end
    check("r6.busy_pre", 32'(busy_lost), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    wait_clear(n, bad);
    check("clr3.cycles", 32'(n), 32'd256);
    check("clr3.no_ready_rsp", 32'(bad), 32'd0);
    req_chk("r6.lw0", 1'b0, 32'h0, SZ_W, 32'h0, 32'h0000_0005, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
